debounce_sync: RTL and testbench

DEBOUNCE_SYNC -- requirements
Module: debounce_sync

---
 rtl/debounce_pkg.sv | 18 +
 rtl/sync_ff_chain.sv | 29 ++
 rtl/debounce_sync.sv | 106 ++++++++++
 tb/tb_debounce_sync.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// debounce_pkg
//   Shared definitions for the debounce_sync slice: FSM state encoding and
//   default parameter values. Imported by debounce_sync and the bench.
package debounce_pkg;

    // Two-bit encoding; bit 1 mirrors the level currently presented on Q
    // once the FSM is in a STABLE state.
    typedef enum logic [1:0] {
        STABLE_LOW  = 2'b00,
        WAIT_HIGH   = 2'b01,
        STABLE_HIGH = 2'b11,
        WAIT_LOW    = 2'b10
    } state_t;

    localparam int unsigned DEF_SYNC_STAGES     = 2;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;

endpackage

// File: rtl/sync_ff_chain.sv
// sync_ff_chain
//   Multi-flop synchroniser for a single asynchronous level.
//   Ports:
//     clk  - system clock, rising edge
//     rst  - asynchronous active-low reset, clears every stage
//     d    - asynchronous input level
//     q    - synchronised level (last stage of the chain)
module sync_ff_chain #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// debounce_sync
//   Synchronises a raw bouncing level and only lets a new level through to
//   Q after it has been seen for DEBOUNCE_CYCLES consecutive synchronised
//   samples.
//   Ports:
//     clk   - system clock, rising edge
//     rst   - asynchronous active-low reset
//     D     - raw asynchronous input level
//     Q     - registered, debounced level
//     busy  - registered, high while a candidate level is being qualified
module debounce_sync
    import debounce_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic D,
    output logic Q,
    output logic busy
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s;
    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             q_reg, q_next;
    logic             busy_reg, busy_next;

    sync_ff_chain #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (D),
        .q  (s)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= STABLE_LOW;
            cnt      <= '0;
            q_reg    <= 1'b0;
            busy_reg <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            q_reg    <= q_next;
            busy_reg <= busy_next;
        end
    end

    // The sample that starts a WAIT state counts as the first one, so the
    // exit compare is against DEBOUNCE_CYCLES-1 and cnt never wraps.
    always_comb begin
        state_next = state;
        cnt_next   = '0;
        q_next     = q_reg;
        unique case (state)
            STABLE_LOW: begin
                if (s) begin
                    state_next = WAIT_HIGH;
                    cnt_next   = CNT_W'(1);
                end
            end
            WAIT_HIGH: begin
                if (!s) begin
                    state_next = STABLE_LOW;
                end else if (cnt == CNT_LAST) begin
                    state_next = STABLE_HIGH;
                    q_next     = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            STABLE_HIGH: begin
                if (!s) begin
                    state_next = WAIT_LOW;
                    cnt_next   = CNT_W'(1);
                end
            end
            WAIT_LOW: begin
                if (s) begin
                    state_next = STABLE_HIGH;
                end else if (cnt == CNT_LAST) begin
                    state_next = STABLE_LOW;
                    q_next     = 1'b0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = STABLE_LOW;
                q_next     = 1'b0;
            end
        endcase
        busy_next = (state_next == WAIT_HIGH) || (state_next == WAIT_LOW);
    end

    assign Q    = q_reg;
    assign busy = busy_reg;

endmodule

// File: tb/tb_debounce_sync.sv
// tb_debounce_sync
//   Self-checking bench for debounce_sync. A behavioural model (delay line
//   plus run-length rule) predicts Q and busy every cycle; directed phases
//   add fixed latency, glitch, bounce, reset-abort and edge-pulse checks.
`timescale 1ns/100ps
module tb_debounce_sync;
    import debounce_pkg::*;

    localparam int unsigned SYNC = DEF_SYNC_STAGES;
    localparam int unsigned DC   = DEF_DEBOUNCE_CYCLES;
    localparam int unsigned LAT  = SYNC + DC - 1;

    logic clk;
    logic rst;
    logic D;
    logic Q;
    logic busy;

    int checks;
    int errors;

    // reference model state
    logic pipe[$];
    logic q_m;
    logic busy_m;
    logic run_val;
    int   run_len;

    // downstream edge detector on observed Q
    logic q_prev;
    int   rises;
    int   falls;

    debounce_sync #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .D   (D),
        .Q   (Q),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #1 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        pipe = {};
        for (int unsigned i = 0; i < SYNC; i++) pipe.push_back(1'b0);
        q_m     = 1'b0;
        busy_m  = 1'b0;
        run_val = 1'b0;
        run_len = 0;
    endtask

    // One rising edge: D is delayed SYNC edges, then Q adopts a level once
    // the last DC samples all show it; busy means the sample disagrees with Q.
    task automatic model_edge(input logic d_val);
        logic smp;
        pipe.push_front(d_val);
        smp = pipe.pop_back();
        if (run_len > 0 && smp == run_val) begin
            if (run_len < 1000) run_len++;
        end else begin
            run_val = smp;
            run_len = 1;
        end
        if (run_val != q_m && run_len >= int'(DC)) q_m = run_val;
        busy_m = (smp != q_m);
    endtask

    task automatic track_edges();
        if (Q === 1'b1 && q_prev === 1'b0) rises++;
        if (Q === 1'b0 && q_prev === 1'b1) falls++;
        q_prev = Q;
    endtask

    // Drive D while clk is low, clock once, compare on the falling edge.
    task automatic step(input logic d_val);
        D = d_val;
        @(posedge clk);
        model_edge(d_val);
        @(negedge clk);
        check("Q", Q, q_m);
        check("busy", busy, busy_m);
        track_edges();
    endtask

    task automatic reset_cycle(input logic d_val);
        rst = 1'b0;
        D   = d_val;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check("rst_Q", Q, 1'b0);
        check("rst_busy", busy, 1'b0);
        q_prev = Q;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rises  = 0;
        falls  = 0;
        rst    = 1'b0;
        D      = 1'b0;
        q_prev = 1'b0;
        model_reset();

        // Reset held for 8 ns with D toggling
        @(negedge clk);
        for (int i = 0; i < 4; i++) reset_cycle(i[0]);
        rst = 1'b1;

        // Idle low, then clean rise with fixed latency and busy window
        for (int i = 0; i < 6; i++) step(1'b0);
        for (int unsigned i = 0; i < 8; i++) begin
            step(1'b1);
            check($sformatf("rise_Q_e%0d", i), Q, (i >= LAT));
            check($sformatf("rise_busy_e%0d", i), busy, (i >= SYNC && i < LAT));
        end

        // Clean fall
        for (int unsigned i = 0; i < 8; i++) begin
            step(1'b0);
            check($sformatf("fall_Q_e%0d", i), Q, (i < LAT));
        end

        // Bounce: 1,1,0 then held 1 -> single rise
        rises = 0;
        step(1'b1);
        step(1'b1);
        step(1'b0);
        for (int i = 0; i < 10; i++) step(1'b1);
        check("bounce_rises", rises, 1);
        check("bounce_Q", Q, 1'b1);

        // Back to low, then a 3-cycle glitch that must be rejected
        for (int i = 0; i < 10; i++) step(1'b0);
        rises = 0;
        for (int i = 0; i < 3; i++) step(1'b1);
        for (int i = 0; i < 8; i++) step(1'b0);
        check("glitch_rises", rises, 0);
        check("glitch_Q", Q, 1'b0);
        check("glitch_busy", busy, 1'b0);

        // Reset asserted across edge k+3 of a rise, then full requalification
        for (int i = 0; i < 3; i++) step(1'b1);
        reset_cycle(1'b1);
        rst = 1'b1;
        for (int unsigned i = 0; i < 8; i++) begin
            step(1'b1);
            check($sformatf("rearm_Q_e%0d", i), Q, (i >= LAT));
        end

        // Edge detector: 10 low, 10 high, 10 low -> one rise, one fall
        for (int i = 0; i < 10; i++) step(1'b0);
        rises = 0;
        falls = 0;
        for (int i = 0; i < 10; i++) step(1'b0);
        for (int i = 0; i < 10; i++) step(1'b1);
        for (int i = 0; i < 10; i++) step(1'b0);
        for (int i = 0; i < 6; i++) step(1'b0);
        check("edge_rises", rises, 1);
        check("edge_falls", falls, 1);

        // Randomised runs of varying length with occasional resets
        for (int n = 0; n < 400; n++) begin
            logic lvl;
            int   len;
            lvl = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 7));
            if ($urandom_range(0, 40) == 0) begin
                reset_cycle(lvl);
                rst = 1'b1;
            end
            for (int i = 0; i < len; i++) step(lvl);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time bound so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
